// File: rtl/cla_multiword_seq_if.sv
// Start/busy/done handshake bundle between the operand source, the nibble-serial
// add/sub sequencer and the result consumer.
interface cla_multiword_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract built from one shared 4-bit carry-look-ahead slice,
// processing one nibble per clock from the LSB up with a registered inter-slice carry.
module cla_multiword_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_multiword_seq_if.slave   bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = $clog2(NSLICE);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Single 4-bit CLA slice: returns {carry_out, sum_nibble}.
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             last_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [4:0]       slice_s;
    logic [WIDTH-1:0] merged_s;
    logic             ovf_s;

    // Start is honoured only when no operation is in flight.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            accept_s = bus.start;
        end else begin
            accept_s = 1'b0;
        end
        if (idx_r == IDX_LAST) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Slice datapath: current nibble pair plus carry, merged into the accumulator.
    always_comb begin
        a_nib_s  = a_r[{idx_r, 2'b00} +: 4];
        b_nib_s  = b_r[{idx_r, 2'b00} +: 4];
        slice_s  = cla4(a_nib_s, b_nib_s, carry_r);
        merged_s = acc_r;
        merged_s[{idx_r, 2'b00} +: 4] = slice_s[3:0];
        ovf_s    = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (merged_s[WIDTH-1] != a_r[WIDTH-1]);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and per-nibble accumulation; subtraction is folded into ~b + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
        end else if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            idx_r   <= {IDXW{1'b0}};
        end else if (state_r == ST_RUN) begin
            acc_r   <= merged_s;
            carry_r <= slice_s[4];
            idx_r   <= idx_r + IDXW'(1);
        end
    end

    // Registered outputs; results update only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
            if ((state_r == ST_RUN) && last_s) begin
                sum_r  <= merged_s;
                cout_r <= slice_s[4];
                ovf_r  <= ovf_s;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed bench for the nibble-serial CLA add/sub sequencer at WIDTH=16.
module tb_cla_multiword_seq;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    cla_multiword_seq_if #(.WIDTH(16)) bus ();

    cla_multiword_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and waits (bounded) for done; entered and left at posedge+1.
    task automatic do_op(input logic s, input logic [15:0] xa, input logic [15:0] xb,
                         input logic c, output logic [15:0] o_sum, output logic o_cout,
                         output logic o_ovf, output int edges, output int busy_cnt,
                         output bit timed_out, output bit sum_moved);
        logic [15:0] pre;
        bus.start = 1'b1; bus.sub = s; bus.a = xa; bus.b = xb; bus.cin = c;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = ~xa; bus.b = ~xb; bus.cin = ~c; bus.sub = ~s;
        pre = bus.sum; edges = 0; busy_cnt = 0; timed_out = 1'b1; sum_moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                timed_out = 1'b0;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.sum !== pre) sum_moved = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        o_sum = bus.sum; o_cout = bus.cout; o_ovf = bus.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic run_vectors(input string tag, input logic s, input logic [15:0] xa,
                               input logic [15:0] xb, input logic c, input logic [15:0] es,
                               input logic ec, input logic eo);
        logic [15:0] r_sum; logic r_cout; logic r_ovf;
        int edges; int busy_cnt; bit to; bit moved;
        do_op(s, xa, xb, c, r_sum, r_cout, r_ovf, edges, busy_cnt, to, moved);
        n_cmp++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within 20 cycles", tag);
        end
        n_cmp++;
        if ({r_sum, r_cout, r_ovf} !== {es, ec, eo}) begin
            n_fail++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     tag, r_sum, r_cout, r_ovf, es, ec, eo);
        end
        n_cmp++;
        if ((edges !== 4) || (busy_cnt !== 4)) begin
            n_fail++;
            $display("FAIL %s_latency: got edges=%0d busy_cycles=%0d, want 4 4", tag, edges, busy_cnt);
        end
        n_cmp++;
        if (moved !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_partial: sum changed during RUN, want held", tag);
        end
    endtask

    task automatic test_add();
        run_vectors("add_1234", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_pulse_width: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
        end
        run_vectors("add_ffff", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_vectors("add_7fff", 1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        run_vectors("sub_5m7", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        @(posedge clk); #1;
        run_vectors("sub_8000m1", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_vectors("b2b_first", 1'b0, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_vectors("b2b_second", 1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        bit got_done;
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({got_done, bus.sum, bus.cout, bus.ovf} !== {1'b1, 16'h3333, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_result: got done=%b sum=%h cout=%b ovf=%b, want 1 3333 0 0",
                     got_done, bus.sum, bus.cout, bus.ovf);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL ignore_no_restart: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        logic [15:0] r_sum; logic r_cout; logic r_ovf;
        int edges; int busy_cnt; bit to; bit moved;
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h7FFF; bus.b = 16'h0001; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 19'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got activity after abort, want none");
        end
        do_op(1'b0, 16'h0001, 16'h0001, 1'b0, r_sum, r_cout, r_ovf, edges, busy_cnt, to, moved);
        n_cmp++;
        if ({to, r_sum, r_cout, r_ovf, edges} !== {1'b0, 16'h0002, 1'b0, 1'b0, 32'd4}) begin
            n_fail++;
            $display("FAIL after_reset_op: got timeout=%b sum=%h cout=%b ovf=%b edges=%0d, want 0 0002 0 0 4",
                     to, r_sum, r_cout, r_ovf, edges);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
